store_data_aligner: RTL and testbench

- Store-side counterpart of the load sign/zero-extension path.
- Takes a store request (address, register data, size select) from the execute stage.
- Places the sized data on the correct byte lanes of the 32-bit data-memory write port and generates byte enables.
- Issues one or two word-aligned write beats over a valid/ready handshake; a second beat is needed when the store crosses a word boundary.

---
 rtl/store_pkg.sv | 30 +++
 rtl/store_lane_align.sv | 30 +++
 rtl/store_data_aligner.sv | 136 +++++++++++++
 tb/tb_store_data_aligner.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared encodings and helpers for the store data path.
package store_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Size codes match the load path encoding.
    localparam logic [2:0] SEL_SB = 3'b001;
    localparam logic [2:0] SEL_SH = 3'b010;
    localparam logic [2:0] SEL_SW = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        DONE,
        ERR
    } st_e;

    // Unaligned byte mask for a size code; all zeros marks an illegal code.
    function automatic logic [BE_W-1:0] size_mask(input logic [2:0] sel);
        case (sel)
            SEL_SB:  return 4'b0001;
            SEL_SH:  return 4'b0011;
            SEL_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Steers sized store data onto a two-word lane window and builds byte enables.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]        off,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] data,
    output logic [63:0]       wide64,
    output logic [7:0]        be8,
    output logic              legal,
    output logic              crosses
);

    logic [DATA_W-1:0] sized;
    logic [BE_W-1:0]   mask;

    always_comb begin
        mask = size_mask(sel);
        case (sel)
            SEL_SB:  sized = {24'b0, data[7:0]};
            SEL_SH:  sized = {16'b0, data[15:0]};
            default: sized = data;
        endcase
        wide64  = {32'b0, sized} << {off, 3'b000};
        be8     = {4'b0, mask} << off;
        legal   = |mask;
        crosses = |be8[7:4];
    end

endmodule

// File: rtl/store_data_aligner.sv
// Store request to one or two word-aligned memory write beats with byte enables.
module store_data_aligner
    import store_pkg::*;
#(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [2:0]        selection_input,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              err
);

    st_e               state, state_nxt;
    logic [63:0]       wide64;
    logic [7:0]        be8;
    logic              legal, crosses;
    logic              accept, reject;
    logic [DATA_W-1:0] hi_data, hi_data_d;
    logic [BE_W-1:0]   hi_be, hi_be_d;
    logic              mem_valid_d, done_d, err_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [BE_W-1:0]   mem_be_d;

    store_lane_align u_lane (
        .off     (req_addr[1:0]),
        .sel     (selection_input),
        .data    (req_data),
        .wide64  (wide64),
        .be8     (be8),
        .legal   (legal),
        .crosses (crosses)
    );

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign reject    = !legal || (!ALLOW_MISALIGNED && crosses);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = reject ? ERR : BEAT0;
            BEAT0:   if (mem_ready) state_nxt = (|hi_be) ? BEAT1 : DONE;
            BEAT1:   if (mem_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs; beat fields hold unless a transfer advances.
    always_comb begin
        mem_valid_d = mem_valid;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        hi_data_d   = hi_data;
        hi_be_d     = hi_be;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = wide64[31:0];
                        mem_be_d    = be8[3:0];
                        hi_data_d   = wide64[63:32];
                        hi_be_d     = be8[7:4];
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (|hi_be) begin
                        mem_addr_d  = mem_addr + ADDR_W'(4);
                        mem_wdata_d = hi_data;
                        mem_be_d    = hi_be;
                    end else begin
                        mem_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            hi_data   <= '0;
            hi_be     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_valid <= mem_valid_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_be    <= mem_be_d;
            hi_data   <= hi_data_d;
            hi_be     <= hi_be_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_store_data_aligner.sv
// Randomized bench for store_data_aligner against a byte-level store model.
module tb_store_data_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr, req_data;
    logic [2:0]  selection_input;
    logic        mem_ready;

    logic        rr_a, mv_a, dn_a, er_a;
    logic [31:0] ma_a, wd_a;
    logic [3:0]  be_a;
    logic        rr_b, mv_b, dn_b, er_b;
    logic [31:0] ma_b, wd_b;
    logic [3:0]  be_b;

    always #5 clk = ~clk;

    store_data_aligner #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(rr_a),
        .req_addr(req_addr), .req_data(req_data), .selection_input(selection_input),
        .mem_valid(mv_a), .mem_ready(mem_ready), .mem_addr(ma_a), .mem_wdata(wd_a),
        .mem_be(be_a), .done(dn_a), .err(er_a)
    );

    store_data_aligner #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(rr_b),
        .req_addr(req_addr), .req_data(req_data), .selection_input(selection_input),
        .mem_valid(mv_b), .mem_ready(mem_ready), .mem_addr(ma_b), .mem_wdata(wd_b),
        .mem_be(be_b), .done(dn_b), .err(er_b)
    );

    bit          sel_b;
    logic        o_rr, o_mv, o_dn, o_er;
    logic [31:0] o_ma, o_wd;
    logic [3:0]  o_be;
    assign o_rr = sel_b ? rr_b : rr_a;
    assign o_mv = sel_b ? mv_b : mv_a;
    assign o_dn = sel_b ? dn_b : dn_a;
    assign o_er = sel_b ? er_b : er_a;
    assign o_ma = sel_b ? ma_b : ma_a;
    assign o_wd = sel_b ? wd_b : wd_a;
    assign o_be = sel_b ? be_b : be_a;

    int vectors = 0;
    int miscompares = 0;

    // Observations from the last transaction.
    int          obs_n, obs_done, obs_err, obs_lat, obs_vcyc;
    bit          obs_unstable, obs_noready;
    logic [31:0] obs_addr [2];
    logic [31:0] obs_wd   [2];
    logic [3:0]  obs_be   [2];

    // Model expectations.
    bit          e_err;
    int          e_n;
    logic [31:0] e_addr [2];
    logic [31:0] e_wd   [2];
    logic [3:0]  e_be   [2];

    // Writes each store byte to its own byte address and groups bytes by word.
    task automatic model(input logic [31:0] addr, input logic [2:0] sel,
                         input logic [31:0] data, input bit strict);
        int nb;
        logic [31:0] a, w, w0;
        int idx, lane;
        case (sel)
            3'b001:  nb = 1;
            3'b010:  nb = 2;
            3'b011:  nb = 4;
            default: nb = 0;
        endcase
        e_err = 1'b0;
        e_n = 0;
        for (int i = 0; i < 2; i++) begin
            e_addr[i] = '0; e_wd[i] = '0; e_be[i] = '0;
        end
        if (nb == 0) begin
            e_err = 1'b1;
            return;
        end
        w0 = addr & 32'hFFFF_FFFC;
        for (int k = 0; k < nb; k++) begin
            a = addr + 32'(k);
            w = a & 32'hFFFF_FFFC;
            idx = (w == w0) ? 0 : 1;
            lane = int'(a[1:0]);
            e_addr[idx] = w;
            e_be[idx][lane] = 1'b1;
            e_wd[idx][8*lane +: 8] = data[8*k +: 8];
            if (idx + 1 > e_n) e_n = idx + 1;
        end
        if (strict && e_n > 1) begin
            e_err = 1'b1;
            e_n = 0;
        end
    endtask

    // Issues one request and records beats, pulses and stability; no checking here.
    task automatic run_store(input logic [31:0] addr, input logic [2:0] sel,
                             input logic [31:0] data, input int stall, input bit use_b);
        int stalls;
        bit first;
        logic [31:0] sa, sd;
        logic [3:0] sbe;
        sel_b = use_b;
        obs_n = 0; obs_done = 0; obs_err = 0; obs_lat = 0; obs_vcyc = 0;
        obs_unstable = 1'b0;
        #1;
        obs_noready = !o_rr;
        req_addr = addr; req_data = data; selection_input = sel; mem_ready = 1'b1;
        if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_addr = $urandom; req_data = $urandom; selection_input = 3'($urandom);
        stalls = 0; first = 1'b1; sa = '0; sd = '0; sbe = '0;
        for (int c = 1; c <= stall + 6; c++) begin
            req_valid_a = 1'b0; req_valid_b = 1'b0;
            if (o_dn) begin obs_done++; obs_lat = c; end
            if (o_er) begin obs_err++;  obs_lat = c; end
            if (o_mv) begin
                obs_vcyc++;
                if (first) begin
                    sa = o_ma; sd = o_wd; sbe = o_be; first = 1'b0;
                end else if (obs_n == 0 && (o_ma !== sa || o_wd !== sd || o_be !== sbe)) begin
                    obs_unstable = 1'b1;
                end
                if (obs_n == 0 && stalls < stall) begin
                    mem_ready = 1'b0;
                    stalls++;
                    if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
                end else begin
                    mem_ready = 1'b1;
                    if (obs_n < 2) begin
                        obs_addr[obs_n] = o_ma; obs_wd[obs_n] = o_wd; obs_be[obs_n] = o_be;
                    end
                    obs_n++;
                end
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
        end
        req_valid_a = 1'b0; req_valid_b = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0; mem_ready = 1'b1;
        req_addr = '0; req_data = '0; selection_input = '0; sel_b = 1'b0;
        #2;
        vectors++;
        if ({mv_a, dn_a, er_a, ma_a, wd_a, be_a} !== 71'd0 || rr_a !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_a got mv=%b dn=%b er=%b addr=%h wd=%h be=%b rr=%b want zeros rr=1",
                     mv_a, dn_a, er_a, ma_a, wd_a, be_a, rr_a);
        end
        vectors++;
        if ({mv_b, dn_b, er_b, ma_b, wd_b, be_b} !== 71'd0 || rr_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_b got mv=%b dn=%b er=%b addr=%h wd=%h be=%b rr=%b want zeros rr=1",
                     mv_b, dn_b, er_b, ma_b, wd_b, be_b, rr_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] t_addr [7] = '{32'h1003, 32'h2002, 32'h3001, 32'h3001, 32'h1000,
                                    32'hFFFF_FFFF, 32'h4003};
        logic [31:0] t_data [7] = '{32'hAABBCCDD, 32'h1234ABCD, 32'h11223344, 32'h11223344,
                                    32'h55667788, 32'hCAFEF00D, 32'h0BADBEEF};
        logic [2:0]  t_sel  [7] = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b011, 3'b010};
        bit          t_b    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int t = 0; t < 7; t++) begin
            run_store(t_addr[t], t_sel[t], t_data[t], 0, t_b[t]);
            model(t_addr[t], t_sel[t], t_data[t], t_b[t]);
            vectors++;
            if (obs_err !== (e_err ? 1 : 0) || obs_done !== (e_err ? 0 : 1)) begin
                miscompares++;
                $display("FAIL dir%0d_pulses got err=%0d done=%0d want err=%0d done=%0d",
                         t, obs_err, obs_done, e_err, !e_err);
            end
            vectors++;
            if (obs_n !== e_n || obs_lat !== (e_err ? 1 : 1 + e_n)) begin
                miscompares++;
                $display("FAIL dir%0d_beats got beats=%0d lat=%0d want beats=%0d lat=%0d",
                         t, obs_n, obs_lat, e_n, e_err ? 1 : 1 + e_n);
            end
            for (int b = 0; b < e_n && b < obs_n; b++) begin
                vectors++;
                if (obs_addr[b] !== e_addr[b] || obs_be[b] !== e_be[b] || obs_wd[b] !== e_wd[b]) begin
                    miscompares++;
                    $display("FAIL dir%0d_beat%0d got addr=%h be=%b wd=%h want addr=%h be=%b wd=%h",
                             t, b, obs_addr[b], obs_be[b], obs_wd[b], e_addr[b], e_be[b], e_wd[b]);
                end
            end
            if (e_err) begin
                vectors++;
                if (obs_vcyc !== 0) begin
                    miscompares++;
                    $display("FAIL dir%0d_novalid got valid_cycles=%0d want 0", t, obs_vcyc);
                end
            end
        end
    endtask

    task automatic test_stall();
        run_store(32'h3001, 3'b011, 32'h11223344, 5, 1'b0);
        vectors++;
        if (obs_unstable !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_stable got unstable=%b want 0", obs_unstable);
        end
        vectors++;
        if (obs_n !== 2 || obs_vcyc !== 7 || obs_done !== 1 || obs_lat !== 8) begin
            miscompares++;
            $display("FAIL stall_timing got beats=%0d vcyc=%0d done=%0d lat=%0d want 2 7 1 8",
                     obs_n, obs_vcyc, obs_done, obs_lat);
        end
        vectors++;
        if (obs_addr[1] !== 32'h3004 || obs_be[1] !== 4'b0001 || obs_wd[1] !== 32'h00000011) begin
            miscompares++;
            $display("FAIL stall_beat1 got addr=%h be=%b wd=%h want 00003004 0001 00000011",
                     obs_addr[1], obs_be[1], obs_wd[1]);
        end
    endtask

    task automatic test_reset_mid_beat();
        sel_b = 1'b0;
        req_addr = 32'h3001; req_data = 32'h11223344; selection_input = 3'b011; mem_ready = 1'b1;
        req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        @(negedge clk);
        vectors++;
        if (mv_a !== 1'b1 || ma_a !== 32'h3004) begin
            miscompares++;
            $display("FAIL rst_mid_beat1 got mv=%b addr=%h want 1 00003004", mv_a, ma_a);
        end
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (mv_a !== 1'b0 || rr_a !== 1'b1 || be_a !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_mid_async got mv=%b rr=%b be=%b want 0 1 0000", mv_a, rr_a, be_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_store(32'hFFFF_FFFC, 3'b011, 32'hDEADBEEF, 0, 1'b0);
        vectors++;
        if (obs_noready || obs_n !== 1 || obs_done !== 1 || obs_addr[0] !== 32'hFFFF_FFFC ||
            obs_be[0] !== 4'b1111 || obs_wd[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rst_mid_after got nordy=%b beats=%0d done=%0d addr=%h be=%b wd=%h want 0 1 1 fffffffc 1111 deadbeef",
                     obs_noready, obs_n, obs_done, obs_addr[0], obs_be[0], obs_wd[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, data;
        logic [2:0] sel;
        int stall;
        bit use_b;
        for (int t = 0; t < 40; t++) begin
            addr = $urandom; data = $urandom;
            sel = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(1, 3));
            stall = $urandom_range(0, 3);
            use_b = 1'($urandom_range(0, 1));
            run_store(addr, sel, data, stall, use_b);
            model(addr, sel, data, use_b);
            vectors++;
            if (obs_noready || obs_err !== (e_err ? 1 : 0) || obs_done !== (e_err ? 0 : 1)) begin
                miscompares++;
                $display("FAIL rnd%0d_pulses addr=%h sel=%b got nordy=%b err=%0d done=%0d want err=%0d done=%0d",
                         t, addr, sel, obs_noready, obs_err, obs_done, e_err, !e_err);
            end
            vectors++;
            if (obs_n !== e_n || obs_unstable ||
                obs_lat !== (e_err ? 1 : 1 + e_n + (e_n > 0 ? stall : 0))) begin
                miscompares++;
                $display("FAIL rnd%0d_beats addr=%h sel=%b got beats=%0d lat=%0d unst=%b want beats=%0d lat=%0d",
                         t, addr, sel, obs_n, obs_lat, obs_unstable, e_n, e_err ? 1 : 1 + e_n + stall);
            end
            for (int b = 0; b < e_n && b < obs_n; b++) begin
                vectors++;
                if (obs_addr[b] !== e_addr[b] || obs_be[b] !== e_be[b] || obs_wd[b] !== e_wd[b]) begin
                    miscompares++;
                    $display("FAIL rnd%0d_beat%0d got addr=%h be=%b wd=%h want addr=%h be=%b wd=%h",
                             t, b, obs_addr[b], obs_be[b], obs_wd[b], e_addr[b], e_be[b], e_wd[b]);
                end
            end
            if (e_err) begin
                vectors++;
                if (obs_vcyc !== 0) begin
                    miscompares++;
                    $display("FAIL rnd%0d_novalid got valid_cycles=%0d want 0", t, obs_vcyc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_beat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
